sa_autosa_cdp_dp_mul_shift_sat: RTL and testbench

Output converter placed directly downstream of the CDP datapath multiplier unit. It accepts the signed pINA_BW+pINB_BW product over a valid/ready handshake and applies a configurable arithmetic right shift with round-to-nearest, ties away from zero. It then saturates the result to a signed pOUT_BW output and presents it downstream over a 2-stage, full-throughput, back-pressurable pipeline. It also keeps a saturating count of clipped samples for debug and performance readout.

---
 rtl/sa_autosa_cdp_dp_mul_shift_sat.sv | 117 +++++++++++
 tb/tb_sa_autosa_cdp_dp_mul_shift_sat.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sa_autosa_cdp_dp_mul_shift_sat.sv
// CDP multiplier output converter: arithmetic right shift with round-half-away,
// signed saturation, 2-stage back-pressurable pipeline and a sticky clip counter.
module sa_autosa_cdp_dp_mul_shift_sat #(
  parameter int pIN_BW    = 25,
  parameter int pOUT_BW   = 8,
  parameter int pSHIFT_BW = 5
) (
  input  logic                 autosa_core_clk,
  input  logic                 autosa_core_rstn,
  input  logic                 mul_unit_vld,
  output logic                 mul_unit_rdy,
  input  logic [pIN_BW-1:0]    mul_unit_pd,
  input  logic [pSHIFT_BW-1:0] cfg_shift,
  output logic                 cvt_out_vld,
  input  logic                 cvt_out_rdy,
  output logic [pOUT_BW-1:0]   cvt_out_pd,
  output logic                 cvt_out_sat,
  input  logic                 sat_cnt_clr,
  output logic [31:0]          sat_cnt
);

  // One extra bit so the rounding increment can never wrap.
  localparam int RW = pIN_BW + 1;
  localparam logic signed [RW-1:0] OMAX = RW'((1 << (pOUT_BW - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = -OMAX - RW'(1);

  logic [2:1]               vld_pipe_q;
  logic signed [RW-1:0]     r_d, r_q;
  logic [pOUT_BW-1:0]       pd_d, pd_q;
  logic                     sat_d, sat_q;
  logic [31:0]              cnt_d, cnt_q;
  logic                     s1_adv, s2_adv, s2_load;

  logic signed [RW-1:0]     x_ext, f;
  logic [31:0]              s32;
  logic [pSHIFT_BW-1:0]     sm1;
  logic [pIN_BW-1:0]        mask;
  logic                     g, t, rnd;

  assign s2_adv       = ~vld_pipe_q[2] | cvt_out_rdy;
  assign s1_adv       = ~vld_pipe_q[1] | s2_adv;
  assign s2_load      = s2_adv & vld_pipe_q[1];
  assign mul_unit_rdy = s1_adv;

  // Stage 1: floor shift, then +1 on guard bit (ties go up for x>=0, need sticky for x<0).
  always_comb begin
    x_ext = RW'($signed(mul_unit_pd));
    s32   = 32'(cfg_shift);
    sm1   = cfg_shift - 1'b1;
    f     = x_ext >>> cfg_shift;
    g     = 1'b0;
    mask  = '0;
    t     = 1'b0;
    rnd   = 1'b0;
    r_d   = x_ext;
    if (s32 >= 32'(pIN_BW)) begin
      r_d = '0;
    end else if (s32 != 32'd0) begin
      g    = mul_unit_pd[sm1];
      mask = (pIN_BW'(1) << sm1) - pIN_BW'(1);
      t    = |(mul_unit_pd & mask);
      rnd  = g & (~mul_unit_pd[pIN_BW-1] | t);
      r_d  = f + $signed({{(RW-1){1'b0}}, rnd});
    end
  end

  // Stage 2: clamp to the signed output range.
  always_comb begin
    pd_d  = r_q[pOUT_BW-1:0];
    sat_d = 1'b0;
    if (r_q > OMAX) begin
      pd_d  = OMAX[pOUT_BW-1:0];
      sat_d = 1'b1;
    end else if (r_q < OMIN) begin
      pd_d  = OMIN[pOUT_BW-1:0];
      sat_d = 1'b1;
    end
  end

  // A clear coinciding with a clip event keeps that event.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_cnt_clr)
      cnt_d = (s2_load & sat_d) ? 32'd1 : 32'd0;
    else if (s2_load & sat_d & (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      vld_pipe_q <= '0;
      r_q        <= '0;
      pd_q       <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (s1_adv) begin
        vld_pipe_q[1] <= mul_unit_vld;
        if (mul_unit_vld) r_q <= r_d;
      end
      if (s2_adv) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) begin
          pd_q  <= pd_d;
          sat_q <= sat_d;
        end
      end
    end
  end

  assign cvt_out_vld = vld_pipe_q[2];
  assign cvt_out_pd  = pd_q;
  assign cvt_out_sat = sat_q;
  assign sat_cnt     = cnt_q;

endmodule

// File: tb/tb_sa_autosa_cdp_dp_mul_shift_sat.sv
// Directed bench for the multiplier output converter; scoreboard of expected outputs.
module tb_sa_autosa_cdp_dp_mul_shift_sat;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mul_unit_vld, mul_unit_rdy;
  logic [24:0] mul_unit_pd;
  logic [4:0]  cfg_shift;
  logic        cvt_out_vld, cvt_out_rdy;
  logic [7:0]  cvt_out_pd;
  logic        cvt_out_sat;
  logic        sat_cnt_clr;
  logic [31:0] sat_cnt;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic acc;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  sa_autosa_cdp_dp_mul_shift_sat dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .mul_unit_vld    (mul_unit_vld),
    .mul_unit_rdy    (mul_unit_rdy),
    .mul_unit_pd     (mul_unit_pd),
    .cfg_shift       (cfg_shift),
    .cvt_out_vld     (cvt_out_vld),
    .cvt_out_rdy     (cvt_out_rdy),
    .cvt_out_pd      (cvt_out_pd),
    .cvt_out_sat     (cvt_out_sat),
    .sat_cnt_clr     (sat_cnt_clr),
    .sat_cnt         (sat_cnt)
  );

  // Reference: round magnitude half-up (ties away from zero), then clamp to int8.
  function automatic logic [8:0] model(input logic [24:0] x, input logic [4:0] s);
    longint xv, a, ra, r;
    xv = longint'($signed(x));
    if (s == 0) r = xv;
    else if (s >= 25) r = 0;
    else begin
      a  = (xv < 0) ? -xv : xv;
      ra = (a + (64'sd1 <<< (s - 1))) >>> s;
      r  = (xv < 0) ? -ra : ra;
    end
    if (r > 127) return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe handshakes mid-cycle, then advance past the next rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    acc = mul_unit_vld && mul_unit_rdy;
    if (acc) sb.push_back(model(mul_unit_pd, cfg_shift));
    if (cvt_out_vld && cvt_out_rdy) begin
      out_cnt++;
      if (sb.size() == 0) chk("unexpected_output", 64'(cvt_out_pd), 64'hDEAD);
      else begin
        e = sb.pop_front();
        chk("out_pd", 64'(cvt_out_pd), 64'(e[7:0]));
        chk("out_sat", 64'(cvt_out_sat), 64'(e[8]));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int x, input int s);
    mul_unit_vld = 1'b1;
    mul_unit_pd  = 25'(x);
    cfg_shift    = 5'(s);
    tick();
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    mul_unit_vld = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int xs [5];
    int n, cyc, base;
    xs = '{50, -50, 300, 7, -9};
    rstn = 1'b0; mul_unit_vld = 1'b0; mul_unit_pd = '0; cfg_shift = '0;
    cvt_out_rdy = 1'b1; sat_cnt_clr = 1'b0;
    #12 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_vld", 64'(cvt_out_vld), 64'd0);
    chk("rst_pd", 64'(cvt_out_pd), 64'd0);
    chk("rst_sat", 64'(cvt_out_sat), 64'd0);
    chk("rst_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_rdy", 64'(mul_unit_rdy), 64'd1);

    // Passthrough and saturation
    send(100, 0); send(200, 0); send(-200, 0); send(-128, 0);
    drain();
    chk("pass_satcnt", 64'(sat_cnt), 64'd2);

    // Rounding ties away from zero
    send(40, 4); send(-40, 4); send(-39, 4); send(24, 4); send(-24, 4); send(7, 4);
    drain();
    chk("round_satcnt", 64'(sat_cnt), 64'd2);

    // Large and out-of-range shift
    send(32'h00FF_FFFF, 24); send(-(1 << 24), 24);
    send(32'h00FF_FFFF, 25); send(-(1 << 24), 25); send(12345, 31);
    drain();

    // Back-pressure: only two samples absorbed
    cvt_out_rdy = 1'b0; n = 0; base = out_cnt;
    for (int c = 0; c < 6; c++) begin
      mul_unit_vld = 1'b1; mul_unit_pd = 25'(xs[n]); cfg_shift = 5'd2;
      tick();
      if (acc) begin
        n++;
        if (n == 1) chk("bp_rdy_one", 64'(mul_unit_rdy), 64'd1);
        if (n == 2) chk("bp_rdy_full", 64'(mul_unit_rdy), 64'd0);
      end
      if (n == 2 && sb.size() > 0) chk("bp_hold_pd", 64'(cvt_out_pd), 64'(sb[0][7:0]));
    end
    chk("bp_accepted", 64'(n), 64'd2);
    chk("bp_out_vld", 64'(cvt_out_vld), 64'd1);
    cvt_out_rdy = 1'b1; cyc = 0;
    while (out_cnt < base + 5 && cyc < 20) begin
      mul_unit_vld = (n < 5);
      if (n < 5) mul_unit_pd = 25'(xs[n]);
      tick();
      cyc++;
      if (acc) n++;
    end
    chk("bp_release_cycles", 64'(cyc), 64'd5);
    drain();
    chk("bp_out_count", 64'(out_cnt - base), 64'd5);

    // Counter: clear alone, preset, clear coinciding with an increment
    sat_cnt_clr = 1'b1; tick(); sat_cnt_clr = 1'b0;
    chk("cnt_clr_alone", 64'(sat_cnt), 64'd0);
    send(300, 0); send(-300, 0); send(1000, 0);
    drain();
    chk("cnt_preset", 64'(sat_cnt), 64'd3);
    send(-1000, 0);
    mul_unit_vld = 1'b0; sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("cnt_clr_inc", 64'(sat_cnt), 64'd1);
    drain();
    chk("cnt_after_drain", 64'(sat_cnt), 64'd1);
    sat_cnt_clr = 1'b1; tick(); sat_cnt_clr = 1'b0;
    chk("cnt_clr_again", 64'(sat_cnt), 64'd0);

    // Reset with both stages full
    cvt_out_rdy = 1'b0; n = 0;
    for (int c = 0; c < 4 && n < 2; c++) begin
      mul_unit_vld = 1'b1; mul_unit_pd = 25'(300); cfg_shift = 5'd0;
      tick();
      if (acc) n++;
    end
    mul_unit_vld = 1'b0;
    tick();
    chk("mid_vld", 64'(cvt_out_vld), 64'd1);
    chk("mid_pd", 64'(cvt_out_pd), 64'h7F);
    chk("mid_cnt", 64'(sat_cnt), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", 64'(cvt_out_vld), 64'd0);
    chk("arst_pd", 64'(cvt_out_pd), 64'd0);
    chk("arst_sat", 64'(cvt_out_sat), 64'd0);
    chk("arst_cnt", 64'(sat_cnt), 64'd0);
    sb.delete();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_vld", 64'(cvt_out_vld), 64'd0);
    chk("post_rdy", 64'(mul_unit_rdy), 64'd1);
    chk("post_cnt", 64'(sat_cnt), 64'd0);
    cvt_out_rdy = 1'b1;
    send(5, 0);
    mul_unit_vld = 1'b0;
    chk("lat_edge1_vld", 64'(cvt_out_vld), 64'd0);
    tick();
    chk("lat_edge2_vld", 64'(cvt_out_vld), 64'd1);
    chk("lat_edge2_pd", 64'(cvt_out_pd), 64'd5);
    drain();
    chk("post_out_cnt", 64'(cvt_out_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
